bp_me_cce_req_arbiter: RTL
==========================

Name: bp_me_cce_req_arbiter

Overview:
- Parametrised front end for a CCE request port in the ME unit-test benches.
- Collects LCE requests from num_ch_p independent ready/valid channels.
- Buffers each channel in a private FIFO, then round-robin arbitrates them onto the single valid/yumi request input of one CCE.
- Reports which channel won so the bench or tracer can attribute every request.

Parameters:
- num_ch_p, 2, number of LCE request channels; range 1..16.
- msg_width_p, 128, width of one LCE request message in bits.
- buf_els_p, 2, FIFO depth per channel; power of two, at least 2.
- ch_id_width_lp, derived as max(1, clog2(num_ch_p)), width of the channel index.
- cnt_width_p, 16, width of each statistics counter.

Ports:
- clk_i  in  1  the block's only clock.
- reset_i  in  1  asynchronous, active-high reset.
- ch_req_i  in  num_ch_p*msg_width_p  per-channel request messages; channel k occupies bits [k*msg_width_p +: msg_width_p].
- ch_req_v_i  in  num_ch_p  per-channel valid.
- ch_req_ready_o  out  num_ch_p  per-channel ready.
- lce_req_o  out  msg_width_p  arbitrated message to the CCE.
- lce_req_v_o  out  1  arbitrated message valid.
- lce_req_yumi_i  in  1  CCE consumes the message this cycle.
- lce_req_ch_o  out  ch_id_width_lp  index of the channel driving lce_req_o.
- stat_cnt_o  out  num_ch_p*cnt_width_p  per-channel count of accepted (yumi'd) messages.

Behaviour:
- Reset, asynchronous:
  - All FIFOs empty.
  - Round-robin pointer = 0.
  - Held-grant flag = 0.
  - Counters = 0.
  - While reset_i=1: ch_req_ready_o=0, lce_req_v_o=0, lce_req_o=0, lce_req_ch_o=0.
- Enqueue:
  - Channel k enqueues on the rising edge where ch_req_v_i[k] & ch_req_ready_o[k].
  - ch_req_ready_o[k] = FIFO k not full; it depends only on registered state.
  - A full FIFO does not accept a write in the same cycle it is dequeued. Ready rises one cycle after the dequeue.
- Latency:
  - No bypass. A message enqueued at edge t is visible on lce_req_o in cycle t+1 at the earliest.
  - Throughput: one message per cycle per channel when lce_req_yumi_i is held high.
- Arbitration:
  - lce_req_v_o = any FIFO non-empty.
  - Winner = first non-empty channel starting at the round-robin pointer, searching upward with wrap from num_ch_p-1 to 0.
  - lce_req_o and lce_req_ch_o come from the winner's FIFO head.
- Grant hold:
  - If lce_req_v_o=1 and lce_req_yumi_i=0, set the held-grant flag and latch the winner.
  - While the flag is set, lce_req_o and lce_req_ch_o stay unchanged, even if a higher-priority channel becomes non-empty.
  - The flag clears on yumi.
- Dequeue on lce_req_yumi_i=1:
  - Pop the granted FIFO.
  - Round-robin pointer = granted+1, wrapping to 0 after num_ch_p-1.
  - Increment that channel's counter. Counters wrap modulo 2^cnt_width_p.
- Illegal yumi: lce_req_yumi_i=1 while lce_req_v_o=0 is ignored (no pop, no count). The block must assert on it in simulation.
- Simultaneous events: an enqueue and a dequeue on the same channel in one cycle are both honoured when the FIFO is neither full nor empty. If empty, only the enqueue happens.
- num_ch_p=1: no arbitration, and lce_req_ch_o is constant 0.
- Reset asserted mid-transfer: all buffered messages are discarded immediately. No partial message is ever presented after reset.

Optional Feature:
- Macro: BP_ME_CCE_REQ_ARB_STATS_EN.
- Defined: per-channel counters are implemented and driven onto stat_cnt_o as described under Behaviour.
- Undefined: counters are not instantiated, and stat_cnt_o is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then idle: after reset deasserts, ch_req_ready_o=2'b11, lce_req_v_o=0, stat_cnt_o=0. Asserting reset_i between edges drives ch_req_ready_o to 0 at once.
2. Single channel, num_ch_p=2, buf_els_p=2: write 0xA1 and 0xA2 on channel 1 with yumi low.
   - ch_req_ready_o[1]=0 after the second write.
   - lce_req_o=0xA1 with lce_req_ch_o=1, held for 5 stalled cycles.
   - Yumi then gives 0xA2 next cycle. Counter 1 = 2.
3. Round robin, num_ch_p=4: all four channels preloaded with 0x10,0x20,0x30,0x40 and yumi held high.
   - Output order is ch0,ch1,ch2,ch3, one message per cycle.
   - A refill of ch0 then wins after ch3 (pointer wraps).
4. Grant hold: ch2 is granted and stalled, then ch0 becomes non-empty with pointer=0. Output stays on ch2 until yumi, then ch0 is served.
5. Full/dequeue same cycle: channel FIFO full and yumi'd. Ready stays 0 that cycle, rises next cycle, and a write offered in the yumi cycle is not accepted.
6. Stats build: with the macro defined, 70000 yumis on ch0 with cnt_width_p=16 leave counter0 = 4464. Without the macro, stat_cnt_o=0 throughout.

Source files
------------

// File: rtl/bp_me_cce_req_arbiter.sv
// bp_me_cce_req_arbiter: per-channel FIFOs round-robin arbitrated onto one CCE valid/yumi request port.
// Optional per-channel accept counters when BP_ME_CCE_REQ_ARB_STATS_EN is defined.
module bp_me_cce_req_arbiter #(
  parameter int num_ch_p = 2,
  parameter int msg_width_p = 128,
  parameter int buf_els_p = 2,
  parameter int cnt_width_p = 16,
  localparam int ch_id_width_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_ch_p*msg_width_p-1:0] ch_req_i,
  input  logic [num_ch_p-1:0]             ch_req_v_i,
  output logic [num_ch_p-1:0]             ch_req_ready_o,
  output logic [msg_width_p-1:0]          lce_req_o,
  output logic                            lce_req_v_o,
  input  logic                            lce_req_yumi_i,
  output logic [ch_id_width_lp-1:0]       lce_req_ch_o,
  output logic [num_ch_p*cnt_width_p-1:0] stat_cnt_o
);
  localparam int aw_lp = $clog2(buf_els_p);
  logic [msg_width_p-1:0] mem [num_ch_p][buf_els_p];
  logic [aw_lp:0] wp [num_ch_p];
  logic [aw_lp:0] rp [num_ch_p];
  logic [num_ch_p-1:0] ne, full, enq, deq;
  logic [ch_id_width_lp-1:0] ptr, srch, gnt, held_ch;
  logic held, found, pop;
  always_comb begin
    ne = '0;
    full = '0;
    deq = '0;
    for (int k = 0; k < num_ch_p; k++) begin
      ne[k] = wp[k] != rp[k];
      full[k] = wp[k] == {~rp[k][aw_lp], rp[k][aw_lp-1:0]};
      deq[k] = pop & (int'(gnt) == k);
    end
  end
  // ready is gated by reset so it drops the moment reset_i rises
  assign ch_req_ready_o = ~full & {num_ch_p{~reset_i}};
  assign enq = ch_req_v_i & ch_req_ready_o;
  assign lce_req_v_o = |ne;
  assign pop = lce_req_v_o & lce_req_yumi_i;
  always_comb begin
    int j;
    j = 0;
    srch = '0;
    found = 1'b0;
    for (int i = 0; i < num_ch_p; i++) begin
      j = int'(ptr) + i;
      j = (j >= num_ch_p) ? j - num_ch_p : j;
      if (!found && ne[j]) begin
        found = 1'b1;
        srch = ch_id_width_lp'(j);
      end
    end
  end
  assign gnt = held ? held_ch : srch;
  assign lce_req_ch_o = lce_req_v_o ? gnt : '0;
  assign lce_req_o = lce_req_v_o ? mem[gnt][rp[gnt][aw_lp-1:0]] : '0;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr <= '0;
      held <= 1'b0;
      held_ch <= '0;
      for (int k = 0; k < num_ch_p; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
    end else begin
      held <= lce_req_v_o & ~lce_req_yumi_i;
      held_ch <= gnt;
      if (pop) ptr <= (int'(gnt) == num_ch_p - 1) ? '0 : gnt + 1'b1;
      for (int k = 0; k < num_ch_p; k++) begin
        if (enq[k]) wp[k] <= wp[k] + 1'b1;
        if (deq[k]) rp[k] <= rp[k] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < num_ch_p; k++)
      if (enq[k]) mem[k][wp[k][aw_lp-1:0]] <= ch_req_i[k*msg_width_p +: msg_width_p];
  end
`ifdef BP_ME_CCE_REQ_ARB_STATS_EN
  logic [cnt_width_p-1:0] cnt [num_ch_p];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_ch_p; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < num_ch_p; k++)
        if (deq[k]) cnt[k] <= cnt[k] + 1'b1;
    end
  end
  for (genvar g = 0; g < num_ch_p; g++) begin : g_stat
    assign stat_cnt_o[g*cnt_width_p +: cnt_width_p] = cnt[g];
  end
`else
  assign stat_cnt_o = '0;
`endif
  // a yumi with nothing valid is dropped by the logic above; flag it in simulation
  assert property (@(posedge clk_i) disable iff (reset_i) lce_req_yumi_i |-> lce_req_v_o);
endmodule
